// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants, state type and sizing helper for the serial receive path
package serial_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        RX_IDLE,
        RX_COLLECT
    } rx_state_t;

    function automatic int chunks_per_word(input int length);
        return WORD_W / length;
    endfunction

endpackage

// File: rtl/word_out_buffer.sv
// rtl/word_out_buffer.sv - single-entry valid/ready word holding register with overrun detect
import serial_pkg::*;

module word_out_buffer (
    input  logic              clkTx,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              ready,
    output logic [WORD_W-1:0] data,
    output logic              valid,
    output logic              ovf
);

    // A load is dropped only when the held word is not leaving on this same edge.
    logic blocked;
    assign blocked = valid && !ready;
    assign ovf     = load && blocked;

    always_ff @(posedge clkTx or posedge reset) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load && !blocked) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_receiver_deser.sv
// rtl/serial_receiver_deser.sv - reassembles MSB-first LENGTH-bit chunks into 32-bit words
import serial_pkg::*;

module serial_receiver_deser #(
    parameter int LENGTH = 4
) (
    input  logic              clkTx,
    input  logic              reset,
    input  logic              rx_start,
    input  logic              rx_valid,
    input  logic [LENGTH-1:0] rx_data,
    input  logic              word_ready,
    input  logic              clr_err,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              rx_busy,
    output logic              overrun,
    output logic              frame_err
);

    localparam int N  = chunks_per_word(LENGTH);
    localparam int CW = $clog2(N) + 1;

    rx_state_t         state;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_base;
    logic [WORD_W-1:0] shifted;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_base;
    logic              complete;
    logic              ovf;

    // rx_start throws away any partial word before this edge's chunk is considered.
    always_comb begin
        shreg_base = rx_start ? '0 : shreg;
        cnt_base   = rx_start ? '0 : cnt;
        complete   = rx_valid && (cnt_base == CW'(N - 1));
    end

    generate
        if (LENGTH == WORD_W) begin : g_whole
            assign shifted = rx_data;
        end else begin : g_shift
            assign shifted = {shreg_base[WORD_W-LENGTH-1:0], rx_data};
        end
    endgenerate

    always_ff @(posedge clkTx or posedge reset) begin
        if (reset) begin
            state     <= RX_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_valid) begin
                shreg <= shifted;
                if (complete) begin
                    cnt   <= '0;
                    state <= RX_IDLE;
                end else begin
                    cnt   <= cnt_base + 1'b1;
                    state <= RX_COLLECT;
                end
            end else begin
                shreg <= shreg_base;
                cnt   <= cnt_base;
                state <= (cnt_base == '0) ? RX_IDLE : RX_COLLECT;
            end

            // Set events take priority over a simultaneous clear.
            if (rx_start && (cnt != '0))
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;

            if (ovf)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
        end
    end

    assign rx_busy = (state == RX_COLLECT);

    word_out_buffer u_buf (
        .clkTx     (clkTx),
        .reset     (reset),
        .load      (complete),
        .load_data (shifted),
        .ready     (word_ready),
        .data      (word_data),
        .valid     (word_valid),
        .ovf       (ovf)
    );

endmodule

// File: tb/tb_serial_receiver_deser.sv
// tb/tb_serial_receiver_deser.sv - directed table-driven bench for serial_receiver_deser
module tb_serial_receiver_deser;

    typedef struct {
        logic [3:0]  d;
        logic        v, s, r, c;
        logic [31:0] ed;
        logic        ev, eb, eo, ef;
    } vec_t;

    logic        clkTx = 1'b0;
    logic        reset = 1'b1;
    logic        rx_start = 1'b0, rx_valid = 1'b0, word_ready = 1'b1, clr_err = 1'b0;
    logic [3:0]  rx_data = 4'h0;
    logic [31:0] word_data;
    logic        word_valid, rx_busy, overrun, frame_err;

    logic        tie0 = 1'b0, tie1 = 1'b1;
    logic        v32 = 1'b0, v1 = 1'b0;
    logic [31:0] d32 = 32'h0;
    logic [0:0]  d1 = 1'b0;
    logic [31:0] wd32, wd1;
    logic        wv32, wb32, wo32, wf32, wv1, wb1, wo1, wf1;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    always #5 clkTx = ~clkTx;

    serial_receiver_deser #(.LENGTH(4)) dut (
        .clkTx(clkTx), .reset(reset), .rx_start(rx_start), .rx_valid(rx_valid),
        .rx_data(rx_data), .word_ready(word_ready), .clr_err(clr_err),
        .word_data(word_data), .word_valid(word_valid), .rx_busy(rx_busy),
        .overrun(overrun), .frame_err(frame_err)
    );

    serial_receiver_deser #(.LENGTH(32)) dut32 (
        .clkTx(clkTx), .reset(reset), .rx_start(tie0), .rx_valid(v32),
        .rx_data(d32), .word_ready(tie1), .clr_err(tie0),
        .word_data(wd32), .word_valid(wv32), .rx_busy(wb32),
        .overrun(wo32), .frame_err(wf32)
    );

    serial_receiver_deser #(.LENGTH(1)) dut1 (
        .clkTx(clkTx), .reset(reset), .rx_start(tie0), .rx_valid(v1),
        .rx_data(d1), .word_ready(tie1), .clr_err(tie0),
        .word_data(wd1), .word_valid(wv1), .rx_busy(wb1),
        .overrun(wo1), .frame_err(wf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] d, input logic v, input logic s, input logic r,
                       input logic c, input logic [31:0] ed, input logic ev, input logic eb,
                       input logic eo, input logic ef);
        vec_t t;
        t.d = d; t.v = v; t.s = s; t.r = r; t.c = c;
        t.ed = ed; t.ev = ev; t.eb = eb; t.eo = eo; t.ef = ef;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic [3:0] d, input logic v, input logic s,
                         input logic r, input logic c);
        @(negedge clkTx);
        rx_data = d; rx_valid = v; rx_start = s; word_ready = r; clr_err = c;
        @(posedge clkTx);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ed, input logic ev,
                           input logic eb, input logic eo, input logic ef);
        chk({tag, " word_data"}, word_data, ed);
        chk({tag, " word_valid"}, 32'(word_valid), 32'(ev));
        chk({tag, " rx_busy"}, 32'(rx_busy), 32'(eb));
        chk({tag, " overrun"}, 32'(overrun), 32'(eo));
        chk({tag, " frame_err"}, 32'(frame_err), 32'(ef));
    endtask

    initial begin
        logic [31:0] w;

        // Test 1: DEADBEEF, valid for exactly one cycle
        w = 32'hDEADBEEF;
        for (int i = 7; i >= 1; i--) add(w[i*4 +: 4], 1, 0, 1, 0, 32'h0, 0, 1, 0, 0);
        add(w[3:0], 1, 0, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0);
        add(4'h0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        // Test 2: back-to-back words with no gap
        for (int i = 1; i <= 7; i++) add(4'(i), 1, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0, 0);
        add(4'h8, 1, 0, 1, 0, 32'h12345678, 1, 0, 0, 0);
        for (int i = 9; i <= 15; i++) add(4'(i), 1, 0, 1, 0, 32'h12345678, 0, 1, 0, 0);
        add(4'h0, 1, 0, 1, 0, 32'h9ABCDEF0, 1, 0, 0, 0);
        add(4'h0, 0, 0, 1, 0, 32'h9ABCDEF0, 0, 0, 0, 0);
        // Test 3: overrun with consumer stalled, then clear
        for (int i = 0; i < 7; i++) add(4'h1, 1, 0, 0, 0, 32'h9ABCDEF0, 0, 1, 0, 0);
        add(4'h1, 1, 0, 0, 0, 32'h11111111, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(4'h2, 1, 0, 0, 0, 32'h11111111, 1, 1, 0, 0);
        add(4'h2, 1, 0, 0, 0, 32'h11111111, 1, 0, 1, 0);
        add(4'h0, 0, 0, 0, 1, 32'h11111111, 1, 0, 0, 0);
        add(4'h0, 0, 0, 1, 0, 32'h11111111, 0, 0, 0, 0);
        // Test 4: restart mid-word with rx_start+rx_valid
        for (int i = 1; i <= 3; i++) add(4'(i), 1, 0, 1, 0, 32'h11111111, 0, 1, 0, 0);
        add(4'hA, 1, 1, 1, 0, 32'h11111111, 0, 1, 0, 1);
        for (int i = 1; i <= 6; i++) add(4'(i), 1, 0, 1, 0, 32'h11111111, 0, 1, 0, 1);
        add(4'h7, 1, 0, 1, 0, 32'hA1234567, 1, 0, 0, 1);
        add(4'h0, 0, 0, 1, 1, 32'hA1234567, 0, 0, 0, 0);
        // rx_start alone mid-word, together with clr_err: set wins
        add(4'h5, 1, 0, 1, 0, 32'hA1234567, 0, 1, 0, 0);
        add(4'h5, 1, 0, 1, 0, 32'hA1234567, 0, 1, 0, 0);
        add(4'h0, 0, 1, 1, 1, 32'hA1234567, 0, 0, 0, 1);
        add(4'h0, 0, 0, 1, 1, 32'hA1234567, 0, 0, 0, 0);
        add(4'h0, 0, 1, 1, 0, 32'hA1234567, 0, 0, 0, 0);

        // Reset state
        #1;
        chk_all("reset", 32'h0, 0, 0, 0, 0);
        repeat (2) @(posedge clkTx);
        @(negedge clkTx);
        reset = 1'b0;
        #1;
        chk_all("post_reset", 32'h0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].d, tbl[i].v, tbl[i].s, tbl[i].r, tbl[i].c);
            chk_all($sformatf("row%0d", i), tbl[i].ed, tbl[i].ev, tbl[i].eb, tbl[i].eo, tbl[i].ef);
        end

        // Test 5: reset mid-frame, then a clean frame
        for (int i = 0; i < 5; i++) drive(4'h9, 1, 0, 1, 0);
        chk("mid busy", 32'(rx_busy), 32'h1);
        @(negedge clkTx);
        rx_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 32'h0, 0, 0, 0, 0);
        @(posedge clkTx);
        #1;
        chk_all("held_reset", 32'h0, 0, 0, 0, 0);
        @(negedge clkTx);
        reset = 1'b0;
        w = 32'h0F0F0F0F;
        for (int i = 7; i >= 1; i--) drive(w[i*4 +: 4], 1, 0, 1, 0);
        chk_all("refill", 32'h0, 0, 1, 0, 0);
        drive(w[3:0], 1, 0, 1, 0);
        chk_all("refill_done", 32'h0F0F0F0F, 1, 0, 0, 0);
        drive(4'h0, 0, 0, 1, 0);

        // Test 6: LENGTH=32 and LENGTH=1 builds
        @(negedge clkTx);
        v32 = 1'b1; d32 = 32'hCAFEF00D;
        @(posedge clkTx);
        #1;
        chk("len32 data", wd32, 32'hCAFEF00D);
        chk("len32 valid", 32'(wv32), 32'h1);
        chk("len32 busy", 32'(wb32), 32'h0);
        @(negedge clkTx);
        v32 = 1'b0;
        w = 32'hCAFEF00D;
        for (int i = 31; i >= 0; i--) begin
            @(negedge clkTx);
            v1 = 1'b1; d1 = w[i];
            @(posedge clkTx);
            #1;
            if (i == 1) begin
                chk("len1 busy", 32'(wb1), 32'h1);
                chk("len1 pending", 32'(wv1), 32'h0);
            end
        end
        chk("len1 data", wd1, 32'hCAFEF00D);
        chk("len1 valid", 32'(wv1), 32'h1);
        chk("len1 done", 32'(wb1), 32'h0);
        chk("len32 cleared", 32'(wv32), 32'h0);
        @(negedge clkTx);
        v1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
